// File: rtl/op_imm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : op_imm_pkg
// Purpose  : Shared constants, types and decoder for the OP-IMM sequencer
// Revision : 1.0
// ============================================================================
package op_imm_pkg;

    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADDI      = 3'b000;
    localparam logic [2:0] F3_SLLI      = 3'b001;
    localparam logic [2:0] F3_SLTI      = 3'b010;
    localparam logic [2:0] F3_SLTIU     = 3'b011;
    localparam logic [2:0] F3_XORI      = 3'b100;
    localparam logic [2:0] F3_SRLI_SRAI = 3'b101;
    localparam logic [2:0] F3_ORI       = 3'b110;
    localparam logic [2:0] F3_ANDI      = 3'b111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_SRA  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SLT  = 4'd1,
        OP_SLTU = 4'd2,
        OP_XOR  = 4'd3,
        OP_OR   = 4'd4,
        OP_AND  = 4'd5,
        OP_SLL  = 4'd6,
        OP_SRL  = 4'd7,
        OP_SRA  = 4'd8
    } alu_op_e;

    typedef struct packed {
        alu_op_e op;
        logic    illegal;
    } decode_t;

    function automatic decode_t decode_op_imm(input logic [31:0] instr);
        decode_t    d;
        logic [2:0] f3;
        logic [6:0] f7;
        f3        = instr[14:12];
        f7        = instr[31:25];
        d.op      = OP_ADD;
        d.illegal = (instr[6:0] != OPCODE_OP_IMM);
        case (f3)
            F3_ADDI:  d.op = OP_ADD;
            F3_SLTI:  d.op = OP_SLT;
            F3_SLTIU: d.op = OP_SLTU;
            F3_XORI:  d.op = OP_XOR;
            F3_ORI:   d.op = OP_OR;
            F3_ANDI:  d.op = OP_AND;
            F3_SLLI: begin
                d.op = OP_SLL;
                if (f7 != F7_ZERO) d.illegal = 1'b1;
            end
            F3_SRLI_SRAI: begin
                if (f7 == F7_ZERO)     d.op = OP_SRL;
                else if (f7 == F7_SRA) d.op = OP_SRA;
                else                   d.illegal = 1'b1;
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/op_imm_iter_shifter.sv
`default_nettype none
// ============================================================================
// Module   : op_imm_iter_shifter
// Purpose  : Iterative shifter, up to SHIFT_STEP bit positions per step
// Revision : 1.0
// ============================================================================
module op_imm_iter_shifter #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            left_i,
    input  logic            arith_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [4:0]      shamt_i,
    output logic            done_o,
    output logic [XLEN-1:0] next_o
);

    if (SHIFT_STEP != 1 && SHIFT_STEP != 2 && SHIFT_STEP != 4 && SHIFT_STEP != 8) begin : g_bad_step
        $error("op_imm_iter_shifter: SHIFT_STEP must be 1, 2, 4 or 8");
    end

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    logic [XLEN-1:0] acc_q, acc_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [4:0]      amt;
    logic            left_q, arith_q;

    always_comb begin
        amt = (cnt_q < STEP) ? cnt_q : STEP;
        if (left_q)       acc_d = acc_q << amt;
        else if (arith_q) acc_d = XLEN'($signed(acc_q) >>> amt);
        else              acc_d = acc_q >> amt;
        cnt_d = cnt_q - amt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else if (load_i) begin
            acc_q   <= data_i;
            cnt_q   <= shamt_i;
            left_q  <= left_i;
            arith_q <= arith_i;
        end else if (step_i) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    // Asserted during the step that drains the remaining count.
    assign done_o = (cnt_q <= STEP);
    assign next_o = acc_d;

endmodule
`default_nettype wire

// File: rtl/op_imm_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : op_imm_alu_seq
// Purpose  : RV32I OP-IMM sequencer between decode and register writeback
// Revision : 1.0
// ============================================================================
module op_imm_alu_seq
    import op_imm_pkg::*;
#(
    parameter int SHIFT_STEP = 1,
    parameter int XLEN       = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] rs1_rdata_i,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o,
    output logic            illegal_o,
    output logic            busy_o
);

    if (XLEN != 32) begin : g_bad_xlen
        $error("op_imm_alu_seq: XLEN must be 32");
    end

    localparam int MAX_SHIFT_CYCLES = (31 + SHIFT_STEP - 1) / SHIFT_STEP;

    state_e          state_q, state_d;
    decode_t         dec;
    logic            accept;
    logic            is_shift;
    logic [4:0]      shamt;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_q, rd_d;
    logic            illegal_q, illegal_d;
    logic [5:0]      shift_cycles_q;
    logic            sh_load, sh_step, sh_done;
    logic [XLEN-1:0] sh_next;

    assign dec      = decode_op_imm(instr_i);
    assign accept   = instr_valid_i && instr_ready_o;
    assign shamt    = instr_i[24:20];
    assign imm      = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
    assign is_shift = (dec.op == OP_SLL) || (dec.op == OP_SRL) || (dec.op == OP_SRA);
    assign sh_load  = accept && !dec.illegal && is_shift && (shamt != 5'd0);
    assign sh_step  = (state_q == ST_SHIFT);

    // Shift ops fall through with rs1 here; that covers the shamt==0 case.
    always_comb begin
        case (dec.op)
            OP_ADD:  alu_res = rs1_rdata_i + imm;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_rdata_i) < $signed(imm))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (rs1_rdata_i < imm)};
            OP_XOR:  alu_res = rs1_rdata_i ^ imm;
            OP_OR:   alu_res = rs1_rdata_i | imm;
            OP_AND:  alu_res = rs1_rdata_i & imm;
            default: alu_res = rs1_rdata_i;
        endcase
    end

    op_imm_iter_shifter #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (sh_load),
        .step_i  (sh_step),
        .left_i  (dec.op == OP_SLL),
        .arith_i (dec.op == OP_SRA),
        .data_i  (rs1_rdata_i),
        .shamt_i (shamt),
        .done_o  (sh_done),
        .next_o  (sh_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !dec.illegal)
                    state_d = sh_load ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: if (sh_done)        state_d = ST_DONE;
            ST_DONE:  if (result_ready_i) state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        instr_ready_o  = (state_q == ST_IDLE);
        result_valid_o = (state_q == ST_DONE);
        busy_o         = (state_q != ST_IDLE);
    end

    always_comb begin
        result_d  = result_q;
        rd_d      = rd_q;
        illegal_d = accept && dec.illegal;
        if (accept && !dec.illegal) begin
            result_d = alu_res;
            rd_d     = instr_i[11:7];
        end else if (sh_step && sh_done) begin
            result_d = sh_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q       <= '0;
            rd_q           <= '0;
            illegal_q      <= 1'b0;
            shift_cycles_q <= '0;
        end else begin
            result_q       <= result_d;
            rd_q           <= rd_d;
            illegal_q      <= illegal_d;
            shift_cycles_q <= sh_step ? shift_cycles_q + 6'd1 : 6'd0;
        end
    end

    assign result_o  = result_q;
    assign rd_addr_o = rd_q;
    assign illegal_o = illegal_q;

    a_funct3_known: assert property (@(posedge clk) disable iff (!rst_n)
        (accept && instr_i[6:0] == OPCODE_OP_IMM) |-> !$isunknown(instr_i[14:12]));

    a_result_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (result_valid_o && !result_ready_i) |=> $stable(result_o));

    a_illegal_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(illegal_o && result_valid_o));

    a_shift_bound: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_SHIFT) |-> (shift_cycles_q < 6'(MAX_SHIFT_CYCLES)));

endmodule
`default_nettype wire

// File: tb/tb_op_imm_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_op_imm_alu_seq
// Purpose  : Directed, table-driven bench for op_imm_alu_seq
// Revision : 1.0
// ============================================================================
module tb_op_imm_alu_seq;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] exp_res;
        logic [4:0]  exp_rd;
        bit          exp_ill;
        int          exp_lat;
    } vec_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid_i = 1'b0;
    logic        instr_ready_o;
    logic [31:0] instr_i = '0;
    logic [31:0] rs1_rdata_i = '0;
    logic        result_valid_o;
    logic        result_ready_i = 1'b0;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;
    logic        illegal_o;
    logic        busy_o;

    logic        iv4 = 1'b0;
    logic        ir4;
    logic [31:0] instr4 = '0;
    logic [31:0] rs14 = '0;
    logic        rv4;
    logic        rr4 = 1'b1;
    logic [31:0] res4;
    logic [4:0]  rd4;
    logic        ill4;
    logic        busy4;

    int n_vec = 0;
    int n_err = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    op_imm_alu_seq #(.SHIFT_STEP(1), .XLEN(32)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_valid_i  (instr_valid_i),
        .instr_ready_o  (instr_ready_o),
        .instr_i        (instr_i),
        .rs1_rdata_i    (rs1_rdata_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_o       (result_o),
        .rd_addr_o      (rd_addr_o),
        .illegal_o      (illegal_o),
        .busy_o         (busy_o)
    );

    op_imm_alu_seq #(.SHIFT_STEP(4), .XLEN(32)) u_dut4 (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_valid_i  (iv4),
        .instr_ready_o  (ir4),
        .instr_i        (instr4),
        .rs1_rdata_i    (rs14),
        .result_valid_o (rv4),
        .result_ready_i (rr4),
        .result_o       (res4),
        .rd_addr_o      (rd4),
        .illegal_o      (ill4),
        .busy_o         (busy4)
    );

    function automatic logic [31:0] enc(input logic [11:0] imm, input logic [2:0] f3,
                                        input logic [4:0] rd);
        return {imm, 5'd1, f3, rd, 7'b0010011};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        chk({v.name, "_ready"}, instr_ready_o, 1);
        instr_valid_i  = 1'b1;
        instr_i        = v.instr;
        rs1_rdata_i    = v.rs1;
        result_ready_i = 1'b1;
        tick();
        instr_valid_i = 1'b0;
        if (v.exp_ill) begin
            chk({v.name, "_illegal"}, illegal_o, 1);
            chk({v.name, "_novalid"}, result_valid_o, 0);
            chk({v.name, "_rdy_kept"}, instr_ready_o, 1);
            tick();
            chk({v.name, "_ill_pulse"}, illegal_o, 0);
            chk({v.name, "_novalid2"}, result_valid_o, 0);
        end else begin
            lat = 1;
            while (!result_valid_o && lat < 64) begin
                tick();
                lat++;
            end
            chk({v.name, "_lat"}, lat, v.exp_lat);
            chk({v.name, "_res"}, result_o, v.exp_res);
            chk({v.name, "_rd"}, rd_addr_o, {27'd0, v.exp_rd});
            chk({v.name, "_noill"}, illegal_o, 0);
            tick();
            chk({v.name, "_idle"}, instr_ready_o, 1);
            chk({v.name, "_vdrop"}, result_valid_o, 0);
        end
    endtask

    task automatic run4(input string nm, input logic [31:0] ins, input logic [31:0] rs1,
                        input logic [31:0] exp, input int exp_lat);
        int lat;
        iv4    = 1'b1;
        instr4 = ins;
        rs14   = rs1;
        tick();
        iv4 = 1'b0;
        lat = 1;
        while (!rv4 && lat < 64) begin
            tick();
            lat++;
        end
        chk({nm, "_lat"}, lat, exp_lat);
        chk({nm, "_res"}, res4, exp);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{"addi_m1",   32'hFFF08293, 32'h00000010, 32'h0000000F, 5'd5,  1'b0, 1});
        vecs.push_back('{"addi_wrap", enc(12'h001, 3'b000, 5'd6),  32'hFFFFFFFF, 32'h00000000, 5'd6,  1'b0, 1});
        vecs.push_back('{"slti_t",    enc(12'hFFF, 3'b010, 5'd7),  32'hFFFFFFFE, 32'h00000001, 5'd7,  1'b0, 1});
        vecs.push_back('{"slti_f",    enc(12'hFFF, 3'b010, 5'd8),  32'h00000005, 32'h00000000, 5'd8,  1'b0, 1});
        vecs.push_back('{"sltiu_t",   enc(12'hFFF, 3'b011, 5'd9),  32'h00000005, 32'h00000001, 5'd9,  1'b0, 1});
        vecs.push_back('{"sltiu_eq",  enc(12'hFFF, 3'b011, 5'd10), 32'hFFFFFFFF, 32'h00000000, 5'd10, 1'b0, 1});
        vecs.push_back('{"xori",      enc(12'h0FF, 3'b100, 5'd11), 32'h12345678, 32'h12345687, 5'd11, 1'b0, 1});
        vecs.push_back('{"ori_neg",   enc(12'h800, 3'b110, 5'd12), 32'hA0000000, 32'hFFFFF800, 5'd12, 1'b0, 1});
        vecs.push_back('{"andi",      enc(12'h7F0, 3'b111, 5'd13), 32'h12345678, 32'h00000670, 5'd13, 1'b0, 1});
        vecs.push_back('{"srai4",     32'h40415193, 32'h80000000, 32'hF8000000, 5'd3,  1'b0, 5});
        vecs.push_back('{"slli0",     32'h00009093, 32'h12345678, 32'h12345678, 5'd1,  1'b0, 1});
        vecs.push_back('{"slli31",    enc(12'h01F, 3'b001, 5'd14), 32'h00000001, 32'h80000000, 5'd14, 1'b0, 32});
        vecs.push_back('{"srli8",     enc(12'h008, 3'b101, 5'd15), 32'h80000000, 32'h00800000, 5'd15, 1'b0, 9});
        vecs.push_back('{"srai31",    enc(12'h41F, 3'b101, 5'd16), 32'h80000000, 32'hFFFFFFFF, 5'd16, 1'b0, 32});
        vecs.push_back('{"srli3",     enc(12'h003, 3'b101, 5'd17), 32'hF0F0F0F0, 32'h1E1E1E1E, 5'd17, 1'b0, 4});
        vecs.push_back('{"ill_slli",  32'h40109093, 32'h0, 32'h0, 5'd0, 1'b1, 0});
        vecs.push_back('{"ill_opc",   32'h00000033, 32'h0, 32'h0, 5'd0, 1'b1, 0});
        vecs.push_back('{"ill_srli",  enc(12'h021, 3'b101, 5'd1),  32'h0, 32'h0, 5'd0, 1'b1, 0});

        // Reset state
        repeat (3) tick();
        chk("rst_ready", instr_ready_o, 1);
        chk("rst_valid", result_valid_o, 0);
        chk("rst_illegal", illegal_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_rd", rd_addr_o, 0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure on ANDI: result held, new instructions ignored
        instr_valid_i  = 1'b1;
        instr_i        = enc(12'h0F0, 3'b111, 5'd20);
        rs1_rdata_i    = 32'h12345678;
        result_ready_i = 1'b0;
        tick();
        instr_i     = enc(12'h001, 3'b000, 5'd21);
        rs1_rdata_i = 32'hDEADBEEF;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", result_valid_o, 1);
            chk("bp_result", result_o, 32'h00000070);
            chk("bp_rd", rd_addr_o, 20);
            chk("bp_ready", instr_ready_o, 0);
            chk("bp_busy", busy_o, 1);
            tick();
        end
        instr_valid_i  = 1'b0;
        result_ready_i = 1'b1;
        tick();
        chk("bp_rel_ready", instr_ready_o, 1);
        chk("bp_rel_valid", result_valid_o, 0);
        chk("bp_rel_busy", busy_o, 0);

        // Reset in the third SHIFT cycle of SRLI by 20
        instr_valid_i = 1'b1;
        instr_i       = enc(12'h014, 3'b101, 5'd22);
        rs1_rdata_i   = 32'hFFFF0000;
        tick();
        instr_valid_i = 1'b0;
        chk("ms_busy", busy_o, 1);
        chk("ms_ready", instr_ready_o, 0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("ms_idle", instr_ready_o, 1);
        chk("ms_valid", result_valid_o, 0);
        chk("ms_busy0", busy_o, 0);
        chk("ms_result", result_o, 0);
        chk("ms_rd", rd_addr_o, 0);
        run_vec('{"post_rst_addi", enc(12'h005, 3'b000, 5'd23), 32'h00000010, 32'h00000015, 5'd23, 1'b0, 1});

        // SHIFT_STEP=4 instance
        run4("s4_srai4", 32'h40415193, 32'h80000000, 32'hF8000000, 2);
        run4("s4_srli5", enc(12'h005, 3'b101, 5'd4), 32'h80000000, 32'h04000000, 3);
        run4("s4_srai31", enc(12'h41F, 3'b101, 5'd4), 32'h80000000, 32'hFFFFFFFF, 9);
        run4("s4_slli3", enc(12'h003, 3'b001, 5'd4), 32'h00000001, 32'h00000008, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
